fetch_unit: RTL and testbench

Instruction-fetch stage of the minicpu core, directly upstream of the control unit. It holds the program counter and fetches one word per instruction over a req/ack instruction-memory port. It presents the latched instruction, with its `op`/`funct` fields, to decode and execute, then computes the next PC from the branch/jump/zero outcome returned when the datapath retires the instruction. The core is non-pipelined: one instruction is in flight at a time.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Instruction-fetch bundle: instruction-memory req/ack port plus the decode and retire signals
// exchanged between the fetch stage (master) and the memory/datapath side (slave).
interface fetch_if;
  // imem: req stays high, with addr stable, until an ack cycle; rdata is taken only on that cycle.
  // A request may also drop without an ack when reset cancels it.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic [1:0]  branch;
  logic        zero;
  logic        jump;
  logic [31:0] retire_count;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, op, funct, pc, pc_plus4, retire_count,
    input  imem_ack, imem_rdata, retire, branch, zero, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, op, funct, pc, pc_plus4, retire_count,
    output imem_ack, imem_rdata, retire, branch, zero, jump
  );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined fetch stage: holds the PC, fetches one word per instruction and
// computes the next PC from the jump/branch/zero outcome at retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  fetch_if.master    bus,
  output logic [1:0] o_dbg_state
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retire_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic        w_taken;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  // branch==10 is reserved and falls through as not taken
  assign w_taken      = ((bus.branch == 2'b01) && bus.zero) ||
                        ((bus.branch == 2'b11) && !bus.zero);

  // Jump wins outright so branch/zero may be undefined on jumps.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (w_taken) begin
      w_next_pc = w_pc_plus4 + w_branch_off;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pc           <= PC_INIT;
      r_instr        <= 32'd0;
      r_retire_count <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (bus.retire) begin
            r_pc           <= w_next_pc;
            r_retire_count <= r_retire_count + 32'd1;
            r_state        <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req     = (r_state == ST_FETCH);
  assign bus.imem_addr    = r_pc;
  assign bus.instr        = r_instr;
  assign bus.instr_valid  = (r_state == ST_EXEC);
  assign bus.op           = r_instr[31:26];
  assign bus.funct        = r_instr[5:0];
  assign bus.pc           = r_pc;
  assign bus.pc_plus4     = w_pc_plus4;
  assign bus.retire_count = r_retire_count;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction
// streams checked against an address-level model of the PC sequence.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_count;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic j, input logic [1:0] br, input logic z);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    off = int'($signed(word[15:0]));
    if ((br == 2'b01 && z) || (br == 2'b11 && !z)) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic drive_idle();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.retire     = 1'b0;
    bus.branch     = 2'b00;
    bus.zero       = 1'b0;
    bus.jump       = 1'b0;
  endtask

  // One full instruction, entered at a negedge while the DUT should be in FETCH.
  task automatic do_instr(input logic [31:0] word, input logic j, input logic [1:0] br,
                          input logic z, input int ack_dly, input int exec_dly, input bit spurious);
    logic [31:0] exp_pc;
    logic [31:0] nxt;
    exp_pc = exp_q[0];
    for (int k = 0; k <= ack_dly; k++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL fetch_req: req=%0b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_pc);
      end
      checks++;
      if (bus.retire_count !== m_count || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold: count=%h valid=%0b, required count=%h valid=0", bus.retire_count, bus.instr_valid, m_count);
      end
      bus.imem_ack   = (k == ack_dly);
      bus.imem_rdata = (k == ack_dly) ? word : $urandom();
      bus.retire     = spurious;
      bus.jump       = 1'($urandom_range(0, 1));
      bus.branch     = 2'($urandom_range(0, 3));
      bus.zero       = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    drive_idle();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== word ||
        bus.op !== word[31:26] || bus.funct !== word[5:0]) begin
      errors++;
      $display("FAIL exec_entry: valid=%0b req=%0b instr=%h op=%h funct=%h, required valid=1 req=0 instr=%h",
               bus.instr_valid, bus.imem_req, bus.instr, bus.op, bus.funct, word);
    end
    checks++;
    if (bus.pc !== exp_pc || bus.pc_plus4 !== exp_pc + 32'd4) begin
      errors++;
      $display("FAIL exec_pc: pc=%h pc_plus4=%h, required pc=%h", bus.pc, bus.pc_plus4, exp_pc);
    end
    for (int k = 0; k < exec_dly; k++) begin
      bus.imem_ack   = spurious;
      bus.imem_rdata = ~word;
      @(negedge clk);
      checks++;
      if (bus.instr !== word || bus.instr_valid !== 1'b1 || bus.retire_count !== m_count) begin
        errors++;
        $display("FAIL exec_hold: instr=%h valid=%0b count=%h, required instr=%h valid=1 count=%h",
                 bus.instr, bus.instr_valid, bus.retire_count, word, m_count);
      end
    end
    bus.imem_ack = 1'b0;
    bus.retire   = 1'b1;
    bus.jump     = j;
    bus.branch   = br;
    bus.zero     = z;
    nxt     = model_next(exp_pc, word, j, br, z);
    m_count = m_count + 32'd1;
    @(negedge clk);
    drive_idle();
    void'(exp_q.pop_front());
    exp_q.push_back(nxt);
    checks++;
    if (bus.pc !== nxt || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== nxt) begin
      errors++;
      $display("FAIL retire_pc: pc=%h addr=%h req=%0b valid=%0b, required pc=%h req=1 valid=0",
               bus.pc, bus.imem_addr, bus.imem_req, bus.instr_valid, nxt);
    end
    checks++;
    if (bus.retire_count !== m_count) begin
      errors++;
      $display("FAIL retire_count: count=%h, required %h", bus.retire_count, m_count);
    end
  endtask

  task automatic check_pc_const(input string name, input logic [31:0] want);
    checks++;
    if (bus.pc !== want) begin
      errors++;
      $display("FAIL %s: pc=%h, required %h", name, bus.pc, want);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.retire_count !== 32'd0 ||
          dbg_state !== 2'd0 || bus.pc !== RST_PC || bus.instr !== 32'd0 ||
          bus.op !== 6'd0 || bus.funct !== 6'd0 || bus.pc_plus4 !== 32'h104) begin
        errors++;
        $display("FAIL reset_state: req=%0b valid=%0b count=%h state=%0d pc=%h instr=%h p4=%h",
                 bus.imem_req, bus.instr_valid, bus.retire_count, dbg_state, bus.pc, bus.instr, bus.pc_plus4);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL idle_cycle: req=%0b valid=%0b state=%0d, required req=0 valid=0 state=0",
               bus.imem_req, bus.instr_valid, dbg_state);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL first_fetch: req=%0b addr=%h state=%0d, required req=1 addr=00000100 state=1",
               bus.imem_req, bus.imem_addr, dbg_state);
    end
    exp_q.delete();
    exp_q.push_back(RST_PC);
    m_count = 32'd0;
  endtask

  task automatic test_stalled_memory();
    do_instr(32'h8C43_0004, 1'b0, 2'b00, 1'b0, 3, 0, 1'b0);
    check_pc_const("stall_next_pc", 32'h104);
    checks++;
    if (bus.retire_count !== 32'd1) begin
      errors++;
      $display("FAIL stall_count: count=%h, required 1", bus.retire_count);
    end
  endtask

  task automatic test_branch_offsets();
    do_instr(32'h0800_0080, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0);
    check_pc_const("goto_200", 32'h200);
    do_instr(32'h1000_FFFF, 1'b0, 2'b01, 1'b1, 0, 0, 1'b0);
    check_pc_const("beq_taken_minus1", 32'h200);
    do_instr(32'h1000_FFFF, 1'b0, 2'b11, 1'b1, 1, 0, 1'b0);
    check_pc_const("bne_not_taken", 32'h204);
    do_instr(32'h0800_0080, 1'b1, 2'b00, 1'b0, 0, 1, 1'b0);
    do_instr(32'h1000_0010, 1'b0, 2'b11, 1'b0, 0, 0, 1'b0);
    check_pc_const("bne_taken_plus16", 32'h244);
    do_instr(32'h1000_0010, 1'b0, 2'b10, 1'b1, 0, 0, 1'b0);
    check_pc_const("branch_reserved", 32'h248);
  endtask

  task automatic test_jump();
    do_instr(32'h1000_FF69, 1'b0, 2'b01, 1'b1, 0, 0, 1'b0);
    check_pc_const("back_branch_wrap", 32'hFFFF_FFF0);
    do_instr(32'h0800_0004, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0);
    check_pc_const("jump_region_f", 32'hF000_0010);
    do_instr(32'h0800_0040, 1'b1, 2'bxx, 1'bx, 0, 0, 1'b0);
    check_pc_const("jump_f0000100", 32'hF000_0100);
    do_instr(32'h0BFF_FFFF, 1'b1, 2'b01, 1'b1, 0, 0, 1'b0);
    check_pc_const("jump_top", 32'hFFFF_FFFC);
    do_instr(32'h0000_0020, 1'b0, 2'b00, 1'b0, 0, 0, 1'b0);
    check_pc_const("pc_wrap_zero", 32'h0000_0000);
  endtask

  task automatic test_spurious();
    do_instr(32'h2001_0005, 1'b0, 2'b00, 1'b0, 2, 2, 1'b1);
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    m_count = 32'hFFFF_FFFF;
    do_instr(32'h0000_0020, 1'b0, 2'b00, 1'b0, 1, 1, 1'b1);
    checks++;
    if (bus.retire_count !== 32'd0) begin
      errors++;
      $display("FAIL count_wrap: count=%h, required 00000000", bus.retire_count);
    end
  endtask

  task automatic check_after_reset(input string name);
    checks++;
    if (dbg_state !== 2'd0 || bus.pc !== RST_PC || bus.instr !== 32'd0 || bus.retire_count !== 32'd0 ||
        bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%0d pc=%h instr=%h count=%h req=%0b valid=%0b, required idle at %h",
               name, dbg_state, bus.pc, bus.instr, bus.retire_count, bus.imem_req, bus.instr_valid, RST_PC);
    end
  endtask

  task automatic test_reset_mid();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.retire   = 1'b1;
    reset        = 1'b1;
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    check_after_reset("reset_in_exec");
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    m_count = 32'd0;
    do_instr(32'h0800_0080, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    reset          = 1'b1;
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    check_after_reset("reset_in_fetch");
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    m_count = 32'd0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_instr($urandom(), 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
               1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      do_instr($urandom(), 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_stalled_memory();
    test_branch_offsets();
    test_jump();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
